// File: rtl/if_fetch_if.sv
// Bundle between the fetch stage and its environment: memory arbiter
// port, EX redirect and the IF/ID hand-off.
`timescale 1ns/1ps
interface if_fetch_if #(
    parameter int ADDR_W = 32
);
    logic [5:0]        stall_i;
    logic              branch_flag_i;
    logic [ADDR_W-1:0] branch_target_i;
    logic [7:0]        mem_din_i;
    logic              if_ctrl_req_o;
    logic [ADDR_W-1:0] if_mem_a_o;
    logic [ADDR_W-1:0] if_pc_o;
    logic [31:0]       if_inst_o;
    logic              if_valid_o;

    modport master (
        input  stall_i, branch_flag_i, branch_target_i, mem_din_i,
        output if_ctrl_req_o, if_mem_a_o, if_pc_o, if_inst_o, if_valid_o
    );

    modport slave (
        output stall_i, branch_flag_i, branch_target_i, mem_din_i,
        input  if_ctrl_req_o, if_mem_a_o, if_pc_o, if_inst_o, if_valid_o
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: four byte reads per instruction over the shared byte
// port, little-endian assembly, valid/hold hand-off and branch flush.
`timescale 1ns/1ps
module if_fetch #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rdy,
    if_fetch_if.master bus
);
    typedef enum logic {FETCH, VALID} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [2:0]        issue_cnt_q;
    logic [2:0]        recv_cnt_q;
    logic              pend_q;
    logic              valid_q;
    logic [31:0]       inst_q;

    logic req;
    logic grant;
    logic accept;
    logic unused_stall;

    // rst_n gates the request so the port is quiet while reset is held
    assign req    = rst_n && (state_q == FETCH) && (issue_cnt_q < 3'd4) && rdy;
    assign grant  = req && !bus.stall_i[0];
    assign accept = valid_q && !bus.stall_i[2] && rdy;

    assign bus.if_ctrl_req_o = req;
    assign bus.if_mem_a_o    = req ? pc_q + ADDR_W'(issue_cnt_q) : '0;
    assign bus.if_pc_o       = pc_q;
    assign bus.if_inst_o     = inst_q;
    assign bus.if_valid_o    = valid_q;

    assign unused_stall = ^{bus.stall_i[5:3], bus.stall_i[1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            issue_cnt_q <= 3'd0;
            recv_cnt_q  <= 3'd0;
            pend_q      <= 1'b0;
            valid_q     <= 1'b0;
            inst_q      <= 32'd0;
        end else if (bus.branch_flag_i) begin
            // redirect wins over everything; an in-flight byte is dropped
            state_q     <= FETCH;
            pc_q        <= bus.branch_target_i;
            issue_cnt_q <= 3'd0;
            recv_cnt_q  <= 3'd0;
            pend_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    pend_q <= grant;
                    if (grant) begin
                        issue_cnt_q <= issue_cnt_q + 3'd1;
                    end
                    if (pend_q) begin
                        inst_q[{recv_cnt_q[1:0], 3'b000} +: 8] <= bus.mem_din_i;
                        recv_cnt_q <= recv_cnt_q + 3'd1;
                        if (recv_cnt_q == 3'd3) begin
                            state_q <= VALID;
                            valid_q <= 1'b1;
                        end
                    end
                end
                VALID: begin
                    if (accept) begin
                        state_q     <= FETCH;
                        pc_q        <= pc_q + ADDR_W'(4);
                        issue_cnt_q <= 3'd0;
                        recv_cnt_q  <= 3'd0;
                        pend_q      <= 1'b0;
                        valid_q     <= 1'b0;
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed timing scenarios plus a randomized run
// checked against a transaction-level fetch model and a byte memory.
`timescale 1ns/1ps
module tb_if_fetch;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk = 1'b0;
    logic rst_n;
    logic rdy;
    int   total = 0;
    int   bad   = 0;

    logic [7:0]  mem [0:1023];
    logic        o_req, o_valid;
    logic [31:0] o_a, o_pc, o_inst;

    if_fetch_if #(.ADDR_W(32)) bus ();

    if_fetch #(.ADDR_W(32), .RESET_PC(RESET_PC)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .rdy  (rdy),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        return mem[a[9:0]];
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        rdy = 1'b1;
        bus.stall_i = 6'd0;
        bus.branch_flag_i = 1'b0;
        bus.branch_target_i = 32'd0;
        bus.mem_din_i = 8'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock cycle: apply inputs, sample outputs, then act as the memory
    task automatic run_cycle(input logic [5:0] st, input logic r, input logic br,
                             input logic [31:0] tgt);
        logic        g;
        logic [31:0] a;
        bus.stall_i = st;
        rdy = r;
        bus.branch_flag_i = br;
        bus.branch_target_i = tgt;
        #1;
        o_req = bus.if_ctrl_req_o;
        o_a = bus.if_mem_a_o;
        o_valid = bus.if_valid_o;
        o_inst = bus.if_inst_o;
        o_pc = bus.if_pc_o;
        g = o_req && !st[0];
        a = o_a;
        @(posedge clk);
        #1;
        bus.mem_din_i = g ? mem_byte(a) : 8'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rdy = 1'b1;
        bus.stall_i = 6'd0;
        bus.branch_flag_i = 1'b0;
        bus.branch_target_i = 32'd0;
        bus.mem_din_i = 8'd0;
        @(posedge clk);
        #1;
        total++;
        if ({bus.if_ctrl_req_o, bus.if_mem_a_o, bus.if_valid_o, bus.if_inst_o, bus.if_pc_o}
            !== {1'b0, 32'd0, 1'b0, 32'd0, RESET_PC}) begin
            bad++;
            $display("FAIL reset_state got req=%b a=%h v=%b inst=%h pc=%h want 0/0/0/0/%h",
                     bus.if_ctrl_req_o, bus.if_mem_a_o, bus.if_valid_o, bus.if_inst_o,
                     bus.if_pc_o, RESET_PC);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        int ea [7] = '{0, 1, 2, 3, -1, -1, 4};
        do_reset();
        for (int c = 0; c < 7; c++) begin
            run_cycle(6'd0, 1'b1, 1'b0, 32'd0);
            total++;
            if ({o_req, o_a, o_valid, o_pc} !== {ea[c] >= 0, (ea[c] >= 0) ? 32'(ea[c]) : 32'd0,
                                                 c == 5, (c == 6) ? 32'd4 : 32'd0}) begin
                bad++;
                $display("FAIL basic c=%0d got req=%b a=%h v=%b pc=%h want a=%0d v=%b",
                         c, o_req, o_a, o_valid, o_pc, ea[c], c == 5);
            end
            if (c == 5) begin
                total++;
                if (o_inst !== 32'h00100513) begin
                    bad++;
                    $display("FAIL basic_inst got %h want 00100513", o_inst);
                end
            end
        end
        $display("test_basic done");
    endtask

    task automatic test_ifmem_stall();
        int ea [7] = '{0, 1, 2, 2, 3, -1, -1};
        do_reset();
        for (int c = 0; c < 7; c++) begin
            run_cycle((c == 2) ? 6'b000001 : 6'd0, 1'b1, 1'b0, 32'd0);
            total++;
            if ({o_req, o_a, o_valid} !== {ea[c] >= 0, (ea[c] >= 0) ? 32'(ea[c]) : 32'd0,
                                           c == 6}) begin
                bad++;
                $display("FAIL ifmem_stall c=%0d got req=%b a=%h v=%b want a=%0d v=%b",
                         c, o_req, o_a, o_valid, ea[c], c == 6);
            end
            if (c == 6) begin
                total++;
                if ({o_inst, o_pc} !== {32'h00100513, 32'd0}) begin
                    bad++;
                    $display("FAIL ifmem_stall_inst got %h pc=%h want 00100513 pc=0", o_inst, o_pc);
                end
            end
        end
        $display("test_ifmem_stall done");
    endtask

    task automatic test_id_stall();
        int ea [11] = '{0, 1, 2, 3, -1, -1, -1, -1, -1, -1, 4};
        do_reset();
        for (int c = 0; c < 11; c++) begin
            run_cycle((c >= 5 && c <= 8) ? 6'b000100 : 6'd0, 1'b1, 1'b0, 32'd0);
            total++;
            if ({o_req, o_a, o_valid, o_pc} !== {ea[c] >= 0, (ea[c] >= 0) ? 32'(ea[c]) : 32'd0,
                                                 c >= 5 && c <= 9, (c == 10) ? 32'd4 : 32'd0}) begin
                bad++;
                $display("FAIL id_stall c=%0d got req=%b a=%h v=%b pc=%h want a=%0d", c, o_req,
                         o_a, o_valid, o_pc, ea[c]);
            end
            if (c >= 5 && c <= 9) begin
                total++;
                if (o_inst !== 32'h00100513) begin
                    bad++;
                    $display("FAIL id_stall_hold c=%0d got %h want 00100513", c, o_inst);
                end
            end
        end
        $display("test_id_stall done");
    endtask

    task automatic test_branch();
        int ea [9] = '{0, 1, 2, 'h100, 'h101, 'h102, 'h103, -1, -1};
        do_reset();
        for (int c = 0; c < 9; c++) begin
            run_cycle(6'd0, 1'b1, c == 2, 32'h100);
            total++;
            if ({o_req, o_a, o_valid, o_pc} !== {ea[c] >= 0, (ea[c] >= 0) ? 32'(ea[c]) : 32'd0,
                                                 c == 8, (c >= 3) ? 32'h100 : 32'd0}) begin
                bad++;
                $display("FAIL branch c=%0d got req=%b a=%h v=%b pc=%h want a=%h", c, o_req,
                         o_a, o_valid, o_pc, ea[c]);
            end
            if (c == 8) begin
                total++;
                if (o_inst !== word_at(32'h100)) begin
                    bad++;
                    $display("FAIL branch_inst got %h want %h", o_inst, word_at(32'h100));
                end
            end
        end
        $display("test_branch done");
    endtask

    task automatic test_rdy();
        int ea [8] = '{0, -1, -1, 1, 2, 3, -1, -1};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            run_cycle(6'd0, !(c == 1 || c == 2), 1'b0, 32'd0);
            total++;
            if ({o_req, o_a, o_valid} !== {ea[c] >= 0, (ea[c] >= 0) ? 32'(ea[c]) : 32'd0,
                                           c == 7}) begin
                bad++;
                $display("FAIL rdy c=%0d got req=%b a=%h v=%b want a=%0d v=%b", c, o_req, o_a,
                         o_valid, ea[c], c == 7);
            end
            if (c == 7) begin
                total++;
                if (o_inst !== 32'h00100513) begin
                    bad++;
                    $display("FAIL rdy_inst got %h want 00100513", o_inst);
                end
            end
        end
        $display("test_rdy done");
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int c = 0; c < 3; c++) run_cycle(6'd0, 1'b1, 1'b0, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.if_ctrl_req_o, bus.if_mem_a_o, bus.if_valid_o, bus.if_inst_o, bus.if_pc_o}
            !== {1'b0, 32'd0, 1'b0, 32'd0, RESET_PC}) begin
            bad++;
            $display("FAIL async_reset got req=%b a=%h v=%b inst=%h pc=%h want all clear",
                     bus.if_ctrl_req_o, bus.if_mem_a_o, bus.if_valid_o, bus.if_inst_o, bus.if_pc_o);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            run_cycle(6'd0, 1'b1, 1'b0, 32'd0);
            total++;
            if ({o_req, o_a, o_valid} !== {c < 4, (c < 4) ? 32'(c) : 32'd0, c == 5}) begin
                bad++;
                $display("FAIL async_restart c=%0d got req=%b a=%h v=%b", c, o_req, o_a, o_valid);
            end
            if (c == 5) begin
                total++;
                if (o_inst !== 32'h00100513) begin
                    bad++;
                    $display("FAIL async_restart_inst got %h want 00100513", o_inst);
                end
            end
        end
        $display("test_async_reset done");
    endtask

    task automatic test_wrap();
        logic [31:0] ea [8] = '{32'h0, 32'hFFFFFFFC, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'hFFFFFFFF,
                                32'h0, 32'h0, 32'h0};
        logic        er [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            run_cycle(6'd0, 1'b1, c == 0, 32'hFFFFFFFC);
            total++;
            if ({o_req, o_a, o_valid, o_pc} !== {er[c], ea[c], c == 6,
                                                 (c == 0 || c == 7) ? 32'd0 : 32'hFFFFFFFC}) begin
                bad++;
                $display("FAIL wrap c=%0d got req=%b a=%h v=%b pc=%h want req=%b a=%h", c, o_req,
                         o_a, o_valid, o_pc, er[c], ea[c]);
            end
            if (c == 6) begin
                total++;
                if (o_inst !== word_at(32'hFFFFFFFC)) begin
                    bad++;
                    $display("FAIL wrap_inst got %h want %h", o_inst, word_at(32'hFFFFFFFC));
                end
            end
        end
        $display("test_wrap done");
    endtask

    // Model: an instruction is a set of 4 granted byte reads; each lands one
    // cycle later, and after the fourth lands the word is offered at pc.
    task automatic test_random();
        logic [31:0] exp_pc, tgt;
        logic [5:0]  st;
        logic        r, br, st0, st2, exp_req, in_flight;
        int          issued, landed, delivered;
        do_reset();
        exp_pc = RESET_PC;
        issued = 0;
        landed = 0;
        in_flight = 1'b0;
        delivered = 0;
        for (int c = 0; c < 2000; c++) begin
            st0 = ($urandom_range(0, 3) == 0);
            st2 = ($urandom_range(0, 2) == 0);
            st = {3'($urandom), st2, 1'($urandom), st0};
            r = ($urandom_range(0, 6) != 0);
            br = ($urandom_range(0, 39) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 15))
                                              : 32'($urandom_range(0, 1023));
            run_cycle(st, r, br, tgt);
            exp_req = (issued < 4) && r;
            total++;
            if ({o_req, o_valid} !== {exp_req, landed == 4}) begin
                bad++;
                $display("FAIL rand_ctrl c=%0d got req=%b v=%b want req=%b v=%b", c, o_req,
                         o_valid, exp_req, landed == 4);
            end
            if (o_req && exp_req) begin
                total++;
                if (o_a !== exp_pc + 32'(issued)) begin
                    bad++;
                    $display("FAIL rand_addr c=%0d got %h want %h", c, o_a, exp_pc + 32'(issued));
                end
            end
            if (o_valid) begin
                total++;
                if ({o_pc, o_inst} !== {exp_pc, word_at(exp_pc)}) begin
                    bad++;
                    $display("FAIL rand_inst c=%0d got pc=%h inst=%h want pc=%h inst=%h", c, o_pc,
                             o_inst, exp_pc, word_at(exp_pc));
                end
            end
            if (br) begin
                exp_pc = tgt;
                issued = 0;
                landed = 0;
                in_flight = 1'b0;
            end else if (landed == 4 && !st2 && r) begin
                $display("txn pc=%h inst=%h", exp_pc, word_at(exp_pc));
                delivered++;
                exp_pc = exp_pc + 32'd4;
                issued = 0;
                landed = 0;
                in_flight = 1'b0;
            end else begin
                if (in_flight) landed++;
                in_flight = exp_req && !st0;
                if (in_flight) issued++;
            end
        end
        total++;
        if (delivered < 20) begin
            bad++;
            $display("FAIL rand_progress got %0d instructions want at least 20", delivered);
        end
        $display("test_random done delivered=%0d", delivered);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h13;
        mem[1] = 8'h05;
        mem[2] = 8'h10;
        mem[3] = 8'h00;
        test_reset();
        test_basic();
        test_ifmem_stall();
        test_id_stall();
        test_branch();
        test_rdy();
        test_async_reset();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
